// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM states, hazard actions, stage indices and the stall/flush bus type.
package pipe_ctrl_pkg;

   // Bit positions of the pipeline boundaries on the stall/flush buses
   localparam int STG_PC    = 0;
   localparam int STG_IFID  = 1;
   localparam int STG_IDEX  = 2;
   localparam int STG_EXMEM = 3;
   localparam int STG_MEMWB = 4;

   localparam int DEF_NUM_STAGES = 5;

   typedef logic [DEF_NUM_STAGES-1:0] stall_bus_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_IWAIT = 2'd1,
      ST_DWAIT = 2'd2,
      ST_ERR   = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      ACT_NONE    = 3'd0,
      ACT_DWAIT   = 3'd1,
      ACT_BRANCH  = 3'd2,
      ACT_LOADUSE = 3'd3,
      ACT_IWAIT   = 3'd4
   } action_e;

   // Exactly one hazard action per cycle; a data wait outranks everything.
   function automatic action_e sel_action(
      input logic dmem_wait,
      input logic br,
      input logic load_use,
      input logic imem_wait
   );
      action_e act;
      if (dmem_wait) begin
         act = ACT_DWAIT;
      end else if (br) begin
         act = ACT_BRANCH;
      end else if (load_use) begin
         act = ACT_LOADUSE;
      end else if (imem_wait) begin
         act = ACT_IWAIT;
      end else begin
         act = ACT_NONE;
      end
      return act;
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Free-running event counter; counts cycles where i_inc is high and wraps
// modulo 2^CNT_W.
module perf_cnt
#(
   parameter int CNT_W = 32
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_count;

   // Event counter register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= {CNT_W{1'b0}};
      end else if (i_inc) begin
         r_count <= r_count + ONE;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: resolves data/instruction memory waits, taken
// branches and load-use hazards into per-boundary stall and flush strobes.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_STAGES  = 5,
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  idex_mem_re,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic [REG_ADDR_W-1:0] ifid_r1,
   input  logic [REG_ADDR_W-1:0] ifid_r2,
   input  logic                  ifid_use_r1,
   input  logic                  ifid_use_r2,
   input  logic                  br_en,
   input  logic                  imem_ready,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_STAGES-1:0] flush,
   output logic                  timeout_err,
   output logic [CNT_W-1:0]      cnt_stall,
   output logic [CNT_W-1:0]      cnt_flush
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   // A data wait holds everything up to EX/MEM and bubbles MEM/WB
   localparam logic [NUM_STAGES-1:0] STALL_DWAIT = {1'b0, {(NUM_STAGES-1){1'b1}}};
   localparam logic [NUM_STAGES-1:0] FLUSH_DWAIT = {1'b1, {(NUM_STAGES-1){1'b0}}};

   state_e                r_state;
   state_e                w_state_nxt;
   logic [WAIT_W-1:0]     r_wait_cnt;
   logic [WAIT_W-1:0]     w_wait_nxt;
   logic [WAIT_W-1:0]     w_wait_inc;
   logic                  r_timeout_err;

   logic                  w_dmem_wait;
   logic                  w_imem_wait;
   logic                  w_hit_r1;
   logic                  w_hit_r2;
   logic                  w_load_use;
   action_e               w_action;

   logic [NUM_STAGES-1:0] w_stall;
   logic [NUM_STAGES-1:0] w_flush;
   logic                  w_any_stall;
   logic                  w_any_flush;

   assign w_dmem_wait = dmem_req & ~dmem_ready;
   assign w_imem_wait = ~imem_ready;

   // Register x0 never carries a dependency
   assign w_hit_r1   = ifid_use_r1 & (idex_rd == ifid_r1);
   assign w_hit_r2   = ifid_use_r2 & (idex_rd == ifid_r2);
   assign w_load_use = idex_mem_re & (idex_rd != {REG_ADDR_W{1'b0}}) & (w_hit_r1 | w_hit_r2);

   assign w_action   = sel_action(w_dmem_wait, br_en, w_load_use, w_imem_wait);
   assign w_wait_inc = r_wait_cnt + WAIT_ONE;

   // State, wait counter and sticky error registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= {WAIT_W{1'b0}};
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_wait_cnt    <= w_wait_nxt;
         r_timeout_err <= r_timeout_err | (w_state_nxt == ST_ERR);
      end
   end

   // Next state: the wait counter tracks consecutive wait cycles and trips ERR
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      if (r_state == ST_ERR) begin
         w_state_nxt = ST_ERR;
         w_wait_nxt  = r_wait_cnt;
      end else begin
         case (w_action)
            ACT_DWAIT: begin
               w_wait_nxt = w_wait_inc;
               if (w_wait_inc == WAIT_LIMIT) begin
                  w_state_nxt = ST_ERR;
               end else begin
                  w_state_nxt = ST_DWAIT;
               end
            end
            ACT_IWAIT: begin
               w_wait_nxt = w_wait_inc;
               if (w_wait_inc == WAIT_LIMIT) begin
                  w_state_nxt = ST_ERR;
               end else begin
                  w_state_nxt = ST_IWAIT;
               end
            end
            default: begin
               w_wait_nxt  = {WAIT_W{1'b0}};
               w_state_nxt = ST_RUN;
            end
         endcase
      end
   end

   // Stall/flush decode from state and the selected action
   always_comb begin
      w_stall = {NUM_STAGES{1'b0}};
      w_flush = {NUM_STAGES{1'b0}};
      if (!rst) begin
         w_stall = {NUM_STAGES{1'b0}};
         w_flush = {NUM_STAGES{1'b0}};
      end else if (r_state == ST_ERR) begin
         w_stall = {NUM_STAGES{1'b1}};
         w_flush = {NUM_STAGES{1'b0}};
      end else begin
         case (w_action)
            ACT_DWAIT: begin
               w_stall = STALL_DWAIT;
               w_flush = FLUSH_DWAIT;
            end
            ACT_BRANCH: begin
               w_flush[STG_IFID] = 1'b1;
               w_flush[STG_IDEX] = 1'b1;
            end
            ACT_LOADUSE: begin
               w_stall[STG_PC]   = 1'b1;
               w_stall[STG_IFID] = 1'b1;
               w_flush[STG_IDEX] = 1'b1;
            end
            ACT_IWAIT: begin
               w_stall[STG_PC]   = 1'b1;
               w_flush[STG_IFID] = 1'b1;
            end
            default: begin
               w_stall = {NUM_STAGES{1'b0}};
               w_flush = {NUM_STAGES{1'b0}};
            end
         endcase
      end
   end

   assign w_any_stall = |w_stall;
   assign w_any_flush = |w_flush;

   perf_cnt #(
      .CNT_W   (CNT_W)
   ) u_cnt_stall (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_inc   (w_any_stall),
      .o_count (cnt_stall)
   );

   perf_cnt #(
      .CNT_W   (CNT_W)
   ) u_cnt_flush (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_inc   (w_any_flush),
      .o_count (cnt_flush)
   );

   assign stall       = w_stall;
   assign flush       = w_flush;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of single-cycle hazard vectors plus
// hand-written data-wait, reset-mid-wait and timeout sequences.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        idex_mem_re;
   logic [4:0]  idex_rd;
   logic [4:0]  ifid_r1;
   logic [4:0]  ifid_r2;
   logic        ifid_use_r1;
   logic        ifid_use_r2;
   logic        br_en;
   logic        imem_ready;
   logic        dmem_req;
   logic        dmem_ready;
   stall_bus_t  stall;
   stall_bus_t  flush;
   logic        timeout_err;
   logic [31:0] cnt_stall;
   logic [31:0] cnt_flush;

   int n_cmp = 0;
   int n_err = 0;

   pipe_ctrl #(
      .NUM_STAGES  (5),
      .REG_ADDR_W  (5),
      .MEM_TIMEOUT (15),
      .CNT_W       (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .idex_mem_re (idex_mem_re),
      .idex_rd     (idex_rd),
      .ifid_r1     (ifid_r1),
      .ifid_r2     (ifid_r2),
      .ifid_use_r1 (ifid_use_r1),
      .ifid_use_r2 (ifid_use_r2),
      .br_en       (br_en),
      .imem_ready  (imem_ready),
      .dmem_req    (dmem_req),
      .dmem_ready  (dmem_ready),
      .stall       (stall),
      .flush       (flush),
      .timeout_err (timeout_err),
      .cnt_stall   (cnt_stall),
      .cnt_flush   (cnt_flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       mem_re;
      logic [4:0] rd;
      logic [4:0] r1;
      logic [4:0] r2;
      logic       use1;
      logic       use2;
      logic       br;
      logic       irdy;
      logic       dreq;
      logic       drdy;
      stall_bus_t exp_stall;
      stall_bus_t exp_flush;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic mem_re, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
      input logic use1, input logic use2, input logic br, input logic irdy,
      input logic dreq, input logic drdy, input stall_bus_t s, input stall_bus_t f
   );
      vec_t v;
      v.mem_re = mem_re; v.rd = rd; v.r1 = r1; v.r2 = r2;
      v.use1 = use1; v.use2 = use2; v.br = br; v.irdy = irdy;
      v.dreq = dreq; v.drdy = drdy; v.exp_stall = s; v.exp_flush = f;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      idex_mem_re = 1'b0; idex_rd = 5'd0; ifid_r1 = 5'd0; ifid_r2 = 5'd0;
      ifid_use_r1 = 1'b0; ifid_use_r2 = 1'b0; br_en = 1'b0;
      imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic apply(input vec_t v);
      idex_mem_re = v.mem_re; idex_rd = v.rd; ifid_r1 = v.r1; ifid_r2 = v.r2;
      ifid_use_r1 = v.use1; ifid_use_r2 = v.use2; br_en = v.br;
      imem_ready = v.irdy; dmem_req = v.dreq; dmem_ready = v.drdy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      set_idle();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_s;
      int exp_f;

      //            re  rd     r1     r2     u1    u2    br    irdy  dreq  drdy  stall     flush
      vecs[0]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000);
      vecs[1]  = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00011, 5'b00100);
      vecs[2]  = mk(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00011, 5'b00100);
      vecs[3]  = mk(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000);
      vecs[4]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000);
      vecs[5]  = mk(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000);
      vecs[6]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00110);
      vecs[7]  = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00110);
      vecs[8]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001, 5'b00010);
      vecs[9]  = mk(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00011, 5'b00100);
      vecs[10] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b01111, 5'b10000);
      vecs[11] = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b01111, 5'b10000);
      vecs[12] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000);
      vecs[13] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00110);

      // Reset with hazards present on the inputs: outputs must still read zero
      set_idle();
      rst = 1'b0;
      idex_mem_re = 1'b1; idex_rd = 5'd5; ifid_r1 = 5'd5; ifid_use_r1 = 1'b1;
      dmem_req = 1'b1; dmem_ready = 1'b0;
      #2;
      check("rst_stall", stall, 32'd0);
      check("rst_flush", flush, 32'd0);
      check("rst_cnt_stall", cnt_stall, 32'd0);
      check("rst_cnt_flush", cnt_flush, 32'd0);
      check("rst_timeout", timeout_err, 32'd0);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      rst = 1'b1;

      // Table vectors, each followed by one idle cycle that must be quiet
      exp_s = 0;
      exp_f = 0;
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
         check($sformatf("vec%0d_flush", i), flush, vecs[i].exp_flush);
         if (vecs[i].exp_stall != 5'b00000) exp_s++;
         if (vecs[i].exp_flush != 5'b00000) exp_f++;
         @(negedge clk);
         set_idle();
         #1;
         check($sformatf("vec%0d_idle_stall", i), stall, 32'd0);
         check($sformatf("vec%0d_idle_flush", i), flush, 32'd0);
      end
      @(negedge clk);
      #1;
      check("tbl_cnt_stall", cnt_stall, exp_s);
      check("tbl_cnt_flush", cnt_flush, exp_f);

      // Data wait for three cycles, released the cycle dmem_ready rises
      do_reset();
      @(negedge clk);
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("dw%0d_stall", c), stall, 32'h0f);
         check($sformatf("dw%0d_flush", c), flush, 32'h10);
         @(negedge clk);
      end
      dmem_ready = 1'b1;
      #1;
      check("dw_rel_stall", stall, 32'd0);
      check("dw_rel_flush", flush, 32'd0);
      @(negedge clk);
      set_idle();
      #1;
      check("dw_cnt_stall", cnt_stall, 32'd3);
      check("dw_cnt_flush", cnt_flush, 32'd3);
      check("dw_timeout", timeout_err, 32'd0);

      // Reset in the middle of a data wait; the wait count must not carry over
      @(negedge clk);
      dmem_req = 1'b1; dmem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("mid_pre_stall", stall, 32'h0f);
      rst = 1'b0;
      #1;
      check("mid_rst_stall", stall, 32'd0);
      check("mid_rst_flush", flush, 32'd0);
      check("mid_rst_cnt_stall", cnt_stall, 32'd0);
      check("mid_rst_cnt_flush", cnt_flush, 32'd0);
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      dmem_req = 1'b1; dmem_ready = 1'b0;
      repeat (14) @(negedge clk);
      #1;
      check("mid_14_timeout", timeout_err, 32'd0);
      check("mid_14_stall", stall, 32'h0f);
      dmem_ready = 1'b1;
      @(negedge clk);
      set_idle();
      #1;
      check("mid_after_timeout", timeout_err, 32'd0);
      check("mid_after_stall", stall, 32'd0);

      // Instruction wait held until the timeout trips ERR
      do_reset();
      @(negedge clk);
      imem_ready = 1'b0;
      for (int c = 0; c < 15; c++) begin
         #1;
         check($sformatf("to%0d_stall", c), stall, 32'h01);
         check($sformatf("to%0d_flush", c), flush, 32'h02);
         check($sformatf("to%0d_err", c), timeout_err, 32'd0);
         @(negedge clk);
      end
      #1;
      check("err_timeout", timeout_err, 32'd1);
      check("err_stall", stall, 32'h1f);
      check("err_flush", flush, 32'd0);
      imem_ready = 1'b1;
      br_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("err_hold_timeout", timeout_err, 32'd1);
      check("err_hold_stall", stall, 32'h1f);
      check("err_hold_flush", flush, 32'd0);
      rst = 1'b0;
      #1;
      check("err_rst_stall", stall, 32'd0);
      check("err_rst_flush", flush, 32'd0);
      check("err_rst_timeout", timeout_err, 32'd0);
      check("err_rst_cnt_stall", cnt_stall, 32'd0);
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("post_err_stall", stall, 32'd0);
      check("post_err_timeout", timeout_err, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
